// File: rtl/store_write_unit_pkg.sv
// Shared types and lane-merge helper for the store write path.
// Pure declarations: no latency, no flow control.
package store_pkg;

   localparam int LANE_W = 2;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WAIT,
      WR,
      ERR
   } state_t;

   typedef enum logic [1:0] {
      SZ_WORD,
      SZ_HALF,
      SZ_BYTE
   } size_t;

   // Little-endian lane replace; a halfword uses lane[1] to pick the upper or lower half.
   function automatic logic [31:0] lane_merge(input logic [31:0]       word,
                                              input logic [31:0]       data,
                                              input logic [LANE_W-1:0] lane,
                                              input logic              half);
      logic [31:0] merged;
      merged = word;
      if (half) begin
         if (lane[1]) merged[31:16] = data[15:0];
         else         merged[15:0]  = data[15:0];
      end else begin
         case (lane)
            2'd0:    merged[7:0]   = data[7:0];
            2'd1:    merged[15:8]  = data[7:0];
            2'd2:    merged[23:16] = data[7:0];
            default: merged[31:24] = data[7:0];
         endcase
      end
      return merged;
   endfunction

endpackage

// File: rtl/store_write_unit_if.sv
// Core-side store request bundle (optional req_half when STORE_HALF_EN is defined).
// Valid/ready: the unit holds req_ready low while a store is in flight.
interface store_write_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              req_byte;
`ifdef STORE_HALF_EN
   logic              req_half;
`endif
   logic              done;
   logic              misalign_err;

`ifdef STORE_HALF_EN
   modport master (
      output req_valid, req_addr, req_wdata, req_byte, req_half,
      input  req_ready, done, misalign_err
   );
   modport slave (
      input  req_valid, req_addr, req_wdata, req_byte, req_half,
      output req_ready, done, misalign_err
   );
`else
   modport master (
      output req_valid, req_addr, req_wdata, req_byte,
      input  req_ready, done, misalign_err
   );
   modport slave (
      input  req_valid, req_addr, req_wdata, req_byte,
      output req_ready, done, misalign_err
   );
`endif

endinterface

// File: rtl/store_write_unit_byte_lane_merge.sv
// Combinational merge of new store data into an old word by lane and size.
// Zero latency, no flow control; word size passes the new data through.
module byte_lane_merge
   import store_pkg::*;
(
   input  logic [31:0]       old_word,
   input  logic [31:0]       new_data,
   input  logic [LANE_W-1:0] lane,
   input  size_t             size,
   output logic [31:0]       merged
);

   always_comb begin
      merged = new_data;
      if (size != SZ_WORD) begin
         merged = lane_merge(old_word, new_data, lane, size == SZ_HALF);
      end
   end

endmodule

// File: rtl/store_write_unit.sv
// Store write unit: sw direct write (done N+1), sb/sh read-modify-write (done N+2+RD_LATENCY); STORE_HALF_EN adds sh.
// Backpressure: req_ready is high only in IDLE, so the core stalls for the whole store.
module store_write_unit
   import store_pkg::*;
#(
   parameter int RD_LATENCY = 1,
   parameter int ADDR_W     = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   store_write_unit_if.slave core,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   input  logic [31:0]       mem_rdata,
   output logic              mem_we,
   output logic [31:0]       mem_wdata
);

   localparam logic [2:0] CNT_LAST = 3'(RD_LATENCY - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-3:0]   addr_q;
   logic [LANE_W-1:0]   lane_q;
   logic [31:0]         wdata_q;
   logic [31:0]         rdata_q;
   size_t               size_q;
   logic [2:0]          cnt_q;

   logic                accept;
   logic                wait_last;
   logic                misalign;
   size_t               req_size;
   logic [31:0]         merged;

   always_comb begin
      req_size = SZ_WORD;
      if (core.req_byte) begin
         req_size = SZ_BYTE;
      end
`ifdef STORE_HALF_EN
      else if (core.req_half) begin
         req_size = SZ_HALF;
      end
`endif
      misalign = ((req_size == SZ_WORD) && (core.req_addr[1:0] != 2'b00)) ||
                 ((req_size == SZ_HALF) && core.req_addr[0]);
   end

   assign accept    = core.req_valid && (state_q == IDLE);
   assign wait_last = (state_q == WAIT) && (cnt_q == CNT_LAST);

   byte_lane_merge u_merge (
      .old_word (rdata_q),
      .new_data (wdata_q),
      .lane     (lane_q),
      .size     (size_q),
      .merged   (merged)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      core.req_ready    = 1'b0;
      core.done         = 1'b0;
      core.misalign_err = 1'b0;
      mem_re            = 1'b0;
      mem_we            = 1'b0;
      mem_addr          = '0;
      mem_wdata         = '0;
      case (state_q)
         IDLE: begin
            core.req_ready = 1'b1;
            if (accept) begin
               if (misalign)                 state_d = ERR;
               else if (req_size == SZ_WORD) state_d = WR;
               else                          state_d = RD;
            end
         end
         RD: begin
            mem_re   = 1'b1;
            mem_addr = {addr_q, 2'b00};
            state_d  = WAIT;
         end
         WAIT: begin
            if (wait_last) state_d = WR;
         end
         WR: begin
            mem_we    = 1'b1;
            mem_addr  = {addr_q, 2'b00};
            mem_wdata = merged;
            core.done = 1'b1;
            state_d   = IDLE;
         end
         ERR: begin
            core.done         = 1'b1;
            core.misalign_err = 1'b1;
            state_d           = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request fields are latched once on accept; the read word only in the final WAIT cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         addr_q  <= '0;
         lane_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         size_q  <= SZ_WORD;
         cnt_q   <= '0;
      end else begin
         if (accept) begin
            addr_q  <= core.req_addr[ADDR_W-1:2];
            lane_q  <= core.req_addr[1:0];
            wdata_q <= core.req_wdata;
            size_q  <= req_size;
         end
         if (state_q == RD) begin
            cnt_q <= '0;
         end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + 3'd1;
         end
         if (wait_last) begin
            rdata_q <= mem_rdata;
         end
      end
   end

endmodule
